// File: rtl/rtl_kernel_wizard_1_example_pattern_generator_if.sv
// AXI4-Stream bundle driven by the pattern generator.
interface rtl_kernel_wizard_1_example_pattern_generator_if #(
    parameter int DATA_W = 128
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic              tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/rtl_kernel_wizard_1_example_pattern_generator.sv
// Configurable AXI4-Stream test-pattern source: N packets of L bytes,
// with incrementing, constant or per-lane LFSR data.
module rtl_kernel_wizard_1_example_pattern_generator #(
    parameter int C_M_AXIS_TDATA_WIDTH = 128,
    parameter int C_NUMBER_BIT_WIDTH   = 32,
    parameter int C_LENGTH_WIDTH       = 32,
    parameter int C_PKT_COUNT_WIDTH    = 16
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         ap_start,
    output logic                         ap_done,
    output logic                         ap_idle,
    input  logic [C_LENGTH_WIDTH-1:0]    cfg_length_bytes,
    input  logic [C_PKT_COUNT_WIDTH-1:0] cfg_num_packets,
    input  logic [1:0]                   cfg_mode,
    input  logic [31:0]                  cfg_seed,
    rtl_kernel_wizard_1_example_pattern_generator_if.master m_axis
);

    localparam int N      = C_M_AXIS_TDATA_WIDTH / C_NUMBER_BIT_WIDTH;
    localparam int KEEP_W = C_M_AXIS_TDATA_WIDTH / 8;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic                           ap_start_r;
    logic                           go;
    logic                           cfg_ok;
    logic                           handshake;
    logic                           last_beat;
    logic                           final_pkt;
    logic [C_LENGTH_WIDTH-1:0]      cfg_beats_m1;
    logic [C_LENGTH_WIDTH-1:0]      cfg_rem;
    logic [KEEP_W-1:0]              cfg_last_keep;
    logic [C_LENGTH_WIDTH-1:0]      beat_cnt;
    logic [C_LENGTH_WIDTH-1:0]      beats_m1;
    logic [C_PKT_COUNT_WIDTH-1:0]   pkt_cnt;
    logic [KEEP_W-1:0]              last_keep;
    logic [1:0]                     mode;
    logic [31:0]                    lane [N];

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? LFSR_MASK : 32'h0);
    endfunction

    function automatic logic [31:0] lfsr_seed(input logic [31:0] x);
        return (x == 32'h0) ? 32'h1 : x;
    endfunction

    assign go           = ap_start & ~ap_start_r;
    assign cfg_ok       = (cfg_length_bytes != '0) && (cfg_num_packets != '0);
    assign handshake    = m_axis.tvalid & m_axis.tready;
    assign last_beat    = (beat_cnt == '0);
    assign final_pkt    = (pkt_cnt == C_PKT_COUNT_WIDTH'(1));
    assign cfg_beats_m1 = (cfg_length_bytes - C_LENGTH_WIDTH'(1)) / C_LENGTH_WIDTH'(KEEP_W);
    assign cfg_rem      = cfg_length_bytes % C_LENGTH_WIDTH'(KEEP_W);

    // A zero remainder means the last beat is full, so it keeps every byte.
    always_comb begin
        cfg_last_keep = '0;
        for (int b = 0; b < KEEP_W; b++) begin
            cfg_last_keep[b] = (cfg_rem == '0) || (C_LENGTH_WIDTH'(b) < cfg_rem);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ap_start_r <= 1'b0;
        end else begin
            ap_start_r <= ap_start;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (go) state_nxt = cfg_ok ? RUN : DONE;
            RUN:  if (handshake && last_beat && final_pkt) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ap_idle       = (state == IDLE);
        ap_done       = (state == DONE);
        m_axis.tvalid = (state == RUN);
        m_axis.tlast  = (state == RUN) && last_beat;
        m_axis.tkeep  = '0;
        if (state == RUN) begin
            m_axis.tkeep = last_beat ? last_keep : {KEEP_W{1'b1}};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt  <= '0;
            beats_m1  <= '0;
            pkt_cnt   <= '0;
            last_keep <= '0;
            mode      <= 2'd0;
        end else if (state == IDLE && go && cfg_ok) begin
            beat_cnt  <= cfg_beats_m1;
            beats_m1  <= cfg_beats_m1;
            pkt_cnt   <= cfg_num_packets;
            last_keep <= cfg_last_keep;
            mode      <= cfg_mode;
        end else if (handshake) begin
            if (last_beat) begin
                beat_cnt <= beats_m1;
                pkt_cnt  <= pkt_cnt - C_PKT_COUNT_WIDTH'(1);
            end else begin
                beat_cnt <= beat_cnt - C_LENGTH_WIDTH'(1);
            end
        end
    end

    // Lane registers hold the current beat's data and only step on a handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N; i++) lane[i] <= 32'h0;
        end else if (state == IDLE && go && cfg_ok) begin
            for (int i = 0; i < N; i++) begin
                case (cfg_mode)
                    2'd1:    lane[i] <= cfg_seed;
                    2'd2:    lane[i] <= lfsr_seed(cfg_seed ^ 32'(i));
                    default: lane[i] <= cfg_seed + 32'(i);
                endcase
            end
        end else if (handshake) begin
            for (int i = 0; i < N; i++) begin
                case (mode)
                    2'd1:    lane[i] <= lane[i];
                    2'd2:    lane[i] <= lfsr_next(lane[i]);
                    default: lane[i] <= lane[i] + 32'(N);
                endcase
            end
        end
    end

    always_comb begin
        m_axis.tdata = '0;
        for (int i = 0; i < N; i++) begin
            m_axis.tdata[32*i +: 32] = lane[i];
        end
    end

endmodule
